// File: rtl/conv_pkg.sv
// Shared sizing, types and state encoding for the conv output collector.
// Optional argmax tracking in the top is enabled by COLLECT_MAX_EN.
package conv_pkg;

  localparam int DIM  = 28;
  localparam int K    = 5;
  localparam int ODIM = DIM - K + 1;
  localparam int NPIX = ODIM * ODIM;
  localparam int AW   = $clog2(NPIX);
  localparam int PW   = 8;
  localparam int RW   = $clog2(DIM);

  typedef logic [PW-1:0] pixel_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [RW-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Only meaningful for kept positions (row, col >= K-1).
  function automatic addr_t out_addr(
    input pos_t r,
    input pos_t c
  );
    int a;
    a = (int'(r) - (K - 1)) * ODIM
      + (int'(c) - (K - 1));
    return addr_t'(a);
  endfunction

endpackage

// File: rtl/conv_out_ram.sv
// ODIM x ODIM result buffer: one write port, one registered read port.
// Reads return the pre-write contents on an address collision.
module conv_out_ram
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data
);

  logic [PW-1:0] mem [NPIX];
  logic          in_range;

  assign in_range = rd_addr < addr_t'(NPIX);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= in_range ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/conv_out_collector.sv
// Collects the conv pixel stream, keeps non-border results in a buffer.
// Define COLLECT_MAX_EN to add the max_val/max_addr argmax outputs.
module conv_out_collector
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          in_valid,
  input  logic [PW-1:0] pxl_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data,
  output logic          frame_done,
  output logic [AW:0]   out_count
`ifdef COLLECT_MAX_EN
  ,
  output logic [PW-1:0] max_val,
  output logic [AW-1:0] max_addr
`endif
);

  state_t      state_q;
  state_t      state_d;
  pos_t        row_q;
  pos_t        row_d;
  pos_t        col_q;
  pos_t        col_d;
  pos_t        cur_row;
  pos_t        cur_col;
  logic [AW:0] cnt_q;
  logic [AW:0] cnt_d;
  logic        accept;
  logic        keep;
  logic        last;
  addr_t       waddr;

  // A pixel arriving with frame_start is raster index 0 of the new frame.
  always_comb begin
    cur_row = frame_start ? '0 : row_q;
    cur_col = frame_start ? '0 : col_q;
    accept  = in_valid
            && (frame_start || state_q == COLLECT);
    keep    = accept
            && cur_row >= pos_t'(K - 1)
            && cur_col >= pos_t'(K - 1);
    last    = accept
            && cur_row == pos_t'(DIM - 1)
            && cur_col == pos_t'(DIM - 1);
    waddr   = out_addr(cur_row, cur_col);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = last ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (frame_start) begin
          state_d = last ? DONE : COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d = cur_row;
    col_d = cur_col;
    cnt_d = frame_start ? '0 : cnt_q;
    if (accept) begin
      if (cur_col == pos_t'(DIM - 1)) begin
        col_d = '0;
        if (cur_row == pos_t'(DIM - 1)) begin
          row_d = '0;
        end else begin
          row_d = cur_row + 1'b1;
        end
      end else begin
        col_d = cur_col + 1'b1;
      end
    end
    if (keep) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_done = (state_q == DONE);
  assign out_count  = cnt_q;

  conv_out_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (keep),
    .waddr   (waddr),
    .wdata   (pxl_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef COLLECT_MAX_EN
  // Strict compare so the earliest raster position of a tie wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val  <= '0;
      max_addr <= '0;
    end else if (frame_start) begin
      max_val  <= '0;
      max_addr <= '0;
    end else if (keep && pxl_in > max_val) begin
      max_val  <= pxl_in;
      max_addr <= waddr;
    end
  end
`endif

endmodule

// File: tb/tb_conv_out_collector.sv
// Scoreboard bench for conv_out_collector (COLLECT_MAX_EN adds argmax test).
// Buffer contents are tracked by a reference image filled as pixels are driven.
module tb_conv_out_collector;
  import conv_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          in_valid;
  logic [7:0]    pxl_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_done;
  logic [AW:0]   out_count;
`ifdef COLLECT_MAX_EN
  logic [7:0]    max_val;
  logic [AW-1:0] max_addr;
`endif

  always #5 clk = ~clk;

  conv_out_collector dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .pxl_in      (pxl_in),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
`ifdef COLLECT_MAX_EN
    .max_val     (max_val),
    .max_addr    (max_addr),
`endif
    .out_count   (out_count)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] exp_buf [NPIX];
  logic [7:0] sb_q [$];
  int         m_row;
  int         m_col;
  int         m_cnt;
  logic [7:0] e;

  function automatic logic [7:0] pix(input int mode, input int idx);
    case (mode)
      0:       return 8'(idx % 256);
      1:       return 8'hAA;
      default: begin
        if (idx == 10 * DIM + 12 || idx == 20 * DIM + 20)
          return 8'hF0;
        return 8'(idx % 240);
      end
    endcase
  endfunction

  task automatic quiet;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    rd_en       = 1'b0;
  endtask

  task automatic put_px(input logic [7:0] v);
    in_valid = 1'b1;
    pxl_in   = v;
    if (m_row >= K - 1 && m_col >= K - 1) begin
      exp_buf[(m_row - K + 1) * ODIM + m_col - K + 1] = v;
      m_cnt++;
    end
    if (m_col == DIM - 1) begin
      m_col = 0;
      m_row = (m_row == DIM - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic send_frame(input int mode, input bit gap, input int n);
    @(negedge clk);
    quiet;
    frame_start = 1'b1;
    m_row = 0;
    m_col = 0;
    m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      quiet;
      if (i == 0) begin
        n_chk++;
        if (out_count !== '0 || frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL start_clr: count=%0d done=%b required 0/0",
                   out_count, frame_done);
        end
      end
      if (i == DIM * DIM - 1) begin
        n_chk++;
        if (frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_early: done=%b required 0", frame_done);
        end
      end
      put_px(pix(mode, i));
      if (gap && i < n - 1) begin
        @(negedge clk);
        quiet;
      end
    end
    @(negedge clk);
    quiet;
    if (n == DIM * DIM) begin
      n_chk++;
      if (frame_done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_rise: done=%b required 1", frame_done);
      end
      n_chk++;
      if (out_count !== (AW + 1)'(NPIX)) begin
        n_fail++;
        $display("FAIL count_full: got %0d required %0d",
                 out_count, NPIX);
      end
    end else begin
      n_chk++;
      if (out_count !== (AW + 1)'(m_cnt)) begin
        n_fail++;
        $display("FAIL count_part: got %0d required %0d",
                 out_count, m_cnt);
      end
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i <= NPIX; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb_q.pop_front();
        n_chk++;
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_%s addr %0d: got %0d required %0d",
                   tag, i - 1, rd_data, e);
        end
      end
      quiet;
      if (i < NPIX) begin
        rd_en   = 1'b1;
        rd_addr = AW'(i);
        sb_q.push_back(exp_buf[i]);
      end
    end
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = AW'(NPIX + 24);
    sb_q.push_back(8'h00);
    @(negedge clk);
    e = sb_q.pop_front();
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL rd_oob_%s: got %0d required %0d", tag, rd_data, e);
    end
    rd_addr = AW'(5);
    sb_q.push_back(exp_buf[5]);
    @(negedge clk);
    e = sb_q.pop_front();
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL rd5_%s: got %0d required %0d", tag, rd_data, e);
    end
    rd_en   = 1'b0;
    rd_addr = '1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL rd_hold_%s: got %0d required %0d", tag, rd_data, e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    quiet;
    pxl_in  = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (frame_done !== 1'b0 || out_count !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: done=%b count=%0d rd=%0d required 0/0/0",
               frame_done, out_count, rd_data);
    end
`ifdef COLLECT_MAX_EN
    n_chk++;
    if (max_val !== '0 || max_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_max: val=%0d addr=%0d required 0/0",
               max_val, max_addr);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_full_frame;
    send_frame(0, 1'b0, DIM * DIM);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = AW'(0);
    sb_q.push_back(8'd116);
    @(negedge clk);
    e = sb_q.pop_front();
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL full_buf0: got %0d required %0d", rd_data, e);
    end
    rd_addr = AW'(NPIX - 1);
    sb_q.push_back(8'd15);
    @(negedge clk);
    e = sb_q.pop_front();
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL full_buf575: got %0d required %0d", rd_data, e);
    end
    quiet;
    read_all("full");
  endtask

  task automatic test_abort;
    send_frame(0, 1'b0, 300);
    send_frame(1, 1'b0, DIM * DIM);
    read_all("abort");
  endtask

  task automatic test_gapped;
    send_frame(0, 1'b1, DIM * DIM);
    read_all("gap");
  endtask

  task automatic test_done_ignore;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      quiet;
      in_valid = 1'b1;
      pxl_in   = 8'hFF;
    end
    @(negedge clk);
    quiet;
    n_chk++;
    if (out_count !== (AW + 1)'(NPIX) || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignore: count=%0d done=%b required %0d/1",
               out_count, frame_done, NPIX);
    end
    read_all("done");
  endtask

  task automatic test_rbw;
    @(negedge clk);
    quiet;
    frame_start = 1'b1;
    m_row = 0;
    m_col = 0;
    m_cnt = 0;
    put_px(8'h55);
    for (int i = 1; i <= 4 * DIM + 4; i++) begin
      @(negedge clk);
      quiet;
      if (i == 4 * DIM + 4) begin
        rd_en   = 1'b1;
        rd_addr = AW'(0);
        sb_q.push_back(exp_buf[0]);
      end
      put_px(8'h55);
    end
    @(negedge clk);
    quiet;
    e = sb_q.pop_front();
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL rbw_old: got %0d required %0d", rd_data, e);
    end
    n_chk++;
    if (out_count !== (AW + 1)'(1)) begin
      n_fail++;
      $display("FAIL fs_px_count: got %0d required 1", out_count);
    end
    rd_en   = 1'b1;
    rd_addr = AW'(0);
    sb_q.push_back(exp_buf[0]);
    @(negedge clk);
    quiet;
    e = sb_q.pop_front();
    n_chk++;
    if (rd_data !== e) begin
      n_fail++;
      $display("FAIL rbw_new: got %0d required %0d", rd_data, e);
    end
  endtask

  task automatic test_reset_mid;
    send_frame(0, 1'b0, 400);
    @(negedge clk);
    quiet;
    reset = 1'b1;
    #1;
    n_chk++;
    if (frame_done !== 1'b0 || out_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: done=%b count=%0d required 0/0",
               frame_done, out_count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      quiet;
      in_valid = 1'b1;
      pxl_in   = 8'hFF;
    end
    @(negedge clk);
    quiet;
    n_chk++;
    if (frame_done !== 1'b0 || out_count !== '0) begin
      n_fail++;
      $display("FAIL idle_ignore: done=%b count=%0d required 0/0",
               frame_done, out_count);
    end
    read_all("rst");
  endtask

`ifdef COLLECT_MAX_EN
  task automatic test_max;
    send_frame(2, 1'b0, DIM * DIM);
    n_chk++;
    if (max_val !== 8'hF0) begin
      n_fail++;
      $display("FAIL max_val: got %0d required %0d", max_val, 8'hF0);
    end
    n_chk++;
    if (max_addr !== AW'(152)) begin
      n_fail++;
      $display("FAIL max_addr: got %0d required 152", max_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_gapped();
    test_done_ignore();
    test_rbw();
    test_reset_mid();
`ifdef COLLECT_MAX_EN
    test_max();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
